// File: rtl/wb_demux_pkg.sv
// Shared types and helpers for the Wishbone slave-side page demultiplexer.
package wb_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Unsigned 20-bit offset: pages below base wrap to large values and miss.
  function automatic logic [3:0] page_hit(input logic [19:0] adr,
                                          input logic [19:0] base,
                                          input int unsigned n);
    logic [19:0] off;
    off = adr - base;
    return {(off < 20'(n)), off[2:0]};
  endfunction

endpackage

// File: rtl/wb_page_decode.sv
// Combinational 4 KiB page compare: selects which peripheral a page maps to.
module wb_page_decode
  import wb_demux_pkg::*;
#(
  parameter int unsigned N_SLV     = 4,
  parameter logic [19:0] BASE_PAGE = 20'h30001
) (
  input  logic [19:0] page_i,
  output logic        hit_o,
  output logic [2:0]  idx_o
);

  always_comb begin
    {hit_o, idx_o} = page_hit(page_i, BASE_PAGE, N_SLV);
  end

endmodule

// File: rtl/wb_slave_demux.sv
// Wishbone slave demux: page decode, one-hot peripheral strobe, registered
// response, unmapped-page and timeout error responses, error counter and IRQ.
module wb_slave_demux
  import wb_demux_pkg::*;
#(
  parameter int unsigned N_SLV     = 4,
  parameter logic [19:0] BASE_PAGE = 20'h30001,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rstn_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [N_SLV-1:0]      s_stb_o,
  output logic [15:0]           s_adr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_dat_o,
  input  logic [N_SLV-1:0]      s_ack_i,
  input  logic [32*N_SLV-1:0]   s_dat_i,
  output logic [7:0]            err_cnt_o,
  output logic                  err_irq_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] cap_dat_q, cap_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        irq_q, irq_d;

  logic        dec_hit;
  logic [2:0]  dec_idx;
  logic        sel_ack;
  logic [31:0] sel_dat;
  logic        unused_adr;

  wb_page_decode #(
    .N_SLV     (N_SLV),
    .BASE_PAGE (BASE_PAGE)
  ) u_decode (
    .page_i (wbs_adr_i[31:12]),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    unused_adr = ^wbs_adr_i[11:8];
  end

  // Only the latched slave's ack and data are visible to the FSM.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (idx_q == 3'(i)) begin
        sel_ack = s_ack_i[i];
        sel_dat = s_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = '0;
    cap_dat_d = cap_dat_q;
    rsp_err_d = rsp_err_q;
    ack_d     = 1'b0;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    irq_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (dec_hit) begin
            idx_d   = dec_idx;
            state_d = WAIT;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          cap_dat_d = sel_dat;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (timer_q == TMO_LAST) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        ack_d = 1'b1;
        dat_d = rsp_err_q ? ERR_DATA : cap_dat_q;
        if (rsp_err_q) begin
          irq_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      cap_dat_q <= '0;
      rsp_err_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      cap_dat_q <= cap_dat_d;
      rsp_err_q <= rsp_err_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    s_stb_o = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      s_stb_o[i] = (state_q == WAIT) && (idx_q == 3'(i));
    end
  end

  always_comb begin
    wbs_ack_o = ack_q;
    wbs_dat_o = dat_q;
    err_cnt_o = cnt_q;
    err_irq_o = irq_q;
    s_adr_o   = {8'h00, wbs_adr_i[7:0]};
    s_we_o    = wbs_we_i;
    s_sel_o   = wbs_sel_i;
    s_dat_o   = wbs_dat_i;
  end

endmodule

// File: tb/tb_wb_slave_demux.sv
// Self-checking bench: cycle-indexed expectation schedule built from the
// transaction rules, compared against the demux outputs every cycle.
module tb_wb_slave_demux;

  localparam int unsigned N    = 4;
  localparam logic [19:0] BASE = 20'h30001;
  localparam int unsigned T    = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]       wbs_sel_i = '0;
  logic [31:0]      wbs_adr_i = '0, wbs_dat_i = '0;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic [N-1:0]     s_stb_o;
  logic [15:0]      s_adr_o;
  logic             s_we_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_dat_o;
  logic [N-1:0]     s_ack_i = '0;
  logic [32*N-1:0]  s_dat_i = '0;
  logic [7:0]       err_cnt_o;
  logic             err_irq_o;

  always #5 clk = ~clk;

  wb_slave_demux #(
    .N_SLV     (N),
    .BASE_PAGE (BASE),
    .TIMEOUT   (T),
    .ERR_DATA  (ERRD)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .s_stb_o   (s_stb_o),
    .s_adr_o   (s_adr_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_dat_o   (s_dat_o),
    .s_ack_i   (s_ack_i),
    .s_dat_i   (s_dat_i),
    .err_cnt_o (err_cnt_o),
    .err_irq_o (err_irq_o)
  );

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectations keyed by absolute cycle number.
  logic [N-1:0] exp_stb [int];
  bit           exp_ack [int];
  logic [31:0]  exp_dat [int];
  bit           exp_irq [int];
  logic [7:0]   cnt_at  [int];
  logic [7:0]   model_cnt = '0;
  logic [7:0]   cur_cnt = '0;
  logic [31:0]  cur_dat = '0;
  bit           chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_stb.delete();
    exp_ack.delete();
    exp_dat.delete();
    exp_irq.delete();
    cnt_at.delete();
    model_cnt = '0;
    cur_cnt   = '0;
    cur_dat   = '0;
  endtask

  initial begin : compare
    int c;
    logic [N-1:0] es;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        c = cyc_n;
        if (cnt_at.exists(c)) cur_cnt = cnt_at[c];
        if (exp_ack.exists(c)) cur_dat = exp_dat[c];
        es = exp_stb.exists(c) ? exp_stb[c] : '0;
        chk("stb", 64'(s_stb_o), 64'(es));
        chk("ack", 64'(wbs_ack_o), 64'(exp_ack.exists(c)));
        chk("irq", 64'(err_irq_o), 64'(exp_irq.exists(c)));
        chk("cnt", 64'(err_cnt_o), 64'(cur_cnt));
        chk("dat", 64'(wbs_dat_o), 64'(cur_dat));
        chk("fwd", 64'({s_adr_o, s_we_o, s_sel_o, s_dat_o}),
            64'({8'h00, wbs_adr_i[7:0], wbs_we_i, wbs_sel_i, wbs_dat_i}));
      end
    end
  end

  task automatic rand_sdat();
    for (int i = 0; i < int'(N); i++) s_dat_i[32*i +: 32] = $urandom;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    wbs_cyc_i = 1'($urandom_range(0, 1));
    wbs_stb_i = 1'b0;
    wbs_adr_i = $urandom;
    wbs_we_i  = 1'($urandom_range(0, 1));
    wbs_sel_i = 4'($urandom);
    wbs_dat_i = $urandom;
    s_ack_i   = N'($urandom);
    rand_sdat();
  endtask

  // d: cycle (1 = first WAIT cycle) in which the selected slave acks.
  task automatic do_txn(input logic [31:0] a, input bit w, input int d,
                        input logic [31:0] pdat, input logic [N-1:0] stray, input bit imm,
                        output int k, output int acyc, output logic [N-1:0] stb_first,
                        output int stb_cycles);
    logic [19:0]  off;
    bit           hit, ok;
    int           idx, wcyc, ra;
    logic [N-1:0] selb;
    if (!imm) begin
      @(posedge clk); #1;
    end
    k   = cyc_n;
    off = a[31:12] - BASE;
    hit = (off < 20'(N));
    idx = hit ? int'(off) : 0;
    selb = hit ? (N'(1) << idx) : '0;
    ok  = hit && (d <= int'(T));
    if (hit) begin
      wcyc = ok ? d : int'(T);
      for (int c = k + 1; c <= k + wcyc; c++) exp_stb[c] = selb;
      ra = k + wcyc + 2;
    end else begin
      ra = k + 2;
    end
    exp_ack[ra] = 1'b1;
    exp_dat[ra] = ok ? pdat : ERRD;
    if (!ok) begin
      exp_irq[ra] = 1'b1;
      if (model_cnt != 8'hFF) model_cnt++;
      cnt_at[ra] = model_cnt;
    end
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = a; wbs_we_i = w;
    wbs_sel_i = 4'($urandom); wbs_dat_i = $urandom;
    s_ack_i   = stray & ~selb;
    acyc = -1; stb_first = '0; stb_cycles = 0;
    for (int n = 0; n < int'(T) + 12; n++) begin
      @(posedge clk); #1;
      rand_sdat();
      if (ok && cyc_n == k + d) begin
        s_ack_i = selb | stray;
        s_dat_i[32*idx +: 32] = pdat;
      end else begin
        s_ack_i = stray & ~selb;
      end
      @(negedge clk);
      if (cyc_n == k + 1) stb_first = s_stb_o;
      if (s_stb_o != '0) stb_cycles++;
      if (wbs_ack_o) begin
        acyc = cyc_n;
        break;
      end
    end
    #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; s_ack_i = '0;
    if (acyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_wait @cycle %0d: got no ack expected ack by cycle %0d", cyc_n, ra);
    end
  endtask

  task automatic do_abort(input logic [31:0] a, input int w, output int acks);
    int k, idx;
    logic [N-1:0] selb;
    @(posedge clk); #1;
    k    = cyc_n;
    idx  = int'(a[31:12] - BASE);
    selb = N'(1) << idx;
    for (int c = k + 1; c <= k + w; c++) exp_stb[c] = selb;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = a; wbs_we_i = 1'($urandom_range(0, 1));
    acks = 0;
    for (int n = 0; n < w + 4; n++) begin
      @(posedge clk); #1;
      s_ack_i = N'($urandom) & ~selb;
      if (cyc_n == k + w) wbs_cyc_i = 1'b0;
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    #1;
    wbs_stb_i = 1'b0; s_ack_i = '0;
  endtask

  task automatic do_rst_mid(input logic [31:0] a, input int w);
    int k, idx;
    @(posedge clk); #1;
    k   = cyc_n;
    idx = int'(a[31:12] - BASE);
    for (int c = k + 1; c <= k + w; c++) exp_stb[c] = N'(1) << idx;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = a;
    while (cyc_n < k + w) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_stb", 64'(s_stb_o), 64'(N'(1) << idx));
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_stb", 64'(s_stb_o), 64'(0));
    chk("rst_ack", 64'(wbs_ack_o), 64'(0));
    chk("rst_dat", 64'(wbs_dat_o), 64'(0));
    chk("rst_cnt", 64'(err_cnt_o), 64'(0));
    chk("rst_irq", 64'(err_irq_o), 64'(0));
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int k, a, sc, acks, kind, gap, d;
    logic [N-1:0] sf;
    logic [19:0]  pg;
    bit           prev_txn;

    repeat (3) @(posedge clk);
    #1;
    chk("init_stb", 64'(s_stb_o), 64'(0));
    chk("init_ack", 64'(wbs_ack_o), 64'(0));
    chk("init_dat", 64'(wbs_dat_o), 64'(0));
    chk("init_cnt", 64'(err_cnt_o), 64'(0));
    chk("init_irq", 64'(err_irq_o), 64'(0));
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_txn(32'h3000_2004, 1'b0, 3, 32'h1234_5678, '0, 1'b0, k, a, sf, sc);
    chk("s1_stb", 64'(sf), 64'(4'b0010));
    chk("s1_lat", 64'(a - k), 64'(5));
    chk("s1_stbcyc", 64'(sc), 64'(3));
    chk("s1_dat", 64'(wbs_dat_o), 64'(32'h1234_5678));

    do_txn(32'h3000_9000, 1'b1, 5, $urandom, 4'b1111, 1'b0, k, a, sf, sc);
    chk("s2_stbcyc", 64'(sc), 64'(0));
    chk("s2_lat", 64'(a - k), 64'(2));
    chk("s2_dat", 64'(wbs_dat_o), 64'(32'hDEAD_BEEF));
    chk("s2_irq", 64'(err_irq_o), 64'(1));
    chk("s2_cnt", 64'(err_cnt_o), 64'(1));

    do_txn(32'h3000_1000, 1'b0, 100, 32'h0, '0, 1'b0, k, a, sf, sc);
    chk("s3_stb", 64'(sf), 64'(4'b0001));
    chk("s3_stbcyc", 64'(sc), 64'(16));
    chk("s3_lat", 64'(a - k), 64'(18));
    chk("s3_dat", 64'(wbs_dat_o), 64'(32'hDEAD_BEEF));
    chk("s3_cnt", 64'(err_cnt_o), 64'(2));

    do_txn(32'h3000_1010, 1'b1, 16, 32'hCAFE_0001, 4'b0100, 1'b0, k, a, sf, sc);
    chk("s4_stbcyc", 64'(sc), 64'(16));
    chk("s4_lat", 64'(a - k), 64'(18));
    chk("s4_dat", 64'(wbs_dat_o), 64'(32'hCAFE_0001));
    chk("s4_irq", 64'(err_irq_o), 64'(0));
    chk("s4_cnt", 64'(err_cnt_o), 64'(2));

    do_abort(32'h3000_3000, 4, acks);
    chk("s5_abort_acks", 64'(acks), 64'(0));
    do_rst_mid(32'h3000_4000, 5);
    do_txn(32'h3000_4008, 1'b0, 2, 32'hA5A5_0003, '0, 1'b0, k, a, sf, sc);
    chk("s5_lat", 64'(a - k), 64'(4));
    chk("s5_dat", 64'(wbs_dat_o), 64'(32'hA5A5_0003));
    chk("s5_cnt", 64'(err_cnt_o), 64'(0));
    do_txn(32'h3000_2000, 1'b0, 1, 32'h0B2B_0001, '0, 1'b1, k, a, sf, sc);
    chk("b2b_lat", 64'(a - k), 64'(3));
    chk("b2b_dat", 64'(wbs_dat_o), 64'(32'h0B2B_0001));

    prev_txn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 2);
      repeat (gap) idle_cycle();
      case ($urandom_range(0, 5))
        0: d = int'(T);
        1: d = int'(T) - 1;
        2: d = int'(T) + 1;
        3: d = int'(T) + 5;
        default: d = $urandom_range(1, 6);
      endcase
      if (kind <= 5)      pg = BASE + 20'($urandom_range(0, N - 1));
      else if (kind == 6) pg = BASE + 20'(N) + 20'($urandom_range(0, 50));
      else if (kind == 7) pg = BASE - 20'd1 - 20'($urandom_range(0, 3));
      else                pg = 20'($urandom);
      if (kind == 9) begin
        pg = BASE + 20'($urandom_range(0, N - 1));
        do_abort({pg, 12'($urandom)}, $urandom_range(1, T - 1), acks);
        prev_txn = 1'b0;
      end else begin
        do_txn({pg, 12'($urandom)}, 1'($urandom_range(0, 1)), d, $urandom,
               N'($urandom), prev_txn && (gap == 0), k, a, sf, sc);
        prev_txn = 1'b1;
      end
    end

    for (int i = 0; i < 300; i++) begin
      pg = BASE + 20'(N) + 20'($urandom_range(0, 1000));
      do_txn({pg, 12'($urandom)}, 1'($urandom_range(0, 1)), 1, $urandom,
             N'($urandom), (i > 0), k, a, sf, sc);
    end
    chk("sat_cnt", 64'(err_cnt_o), 64'(8'hFF));
    chk("sat_irq", 64'(err_irq_o), 64'(1));
    repeat (4) idle_cycle();
    @(negedge clk);
    chk("sat_hold", 64'(err_cnt_o), 64'(8'hFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
